// File: rtl/apb_target_capture_fifo.sv
// APB target holding a FIFO of 32-bit words strobed in by local hardware.
// Offers pop/peek/status/threshold registers, sticky error flags and a fill-level interrupt.
module apb_target_capture_fifo #(
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,
    input  logic [31:0] apb_request__paddr,
    input  logic        apb_request__penable,
    input  logic        apb_request__psel,
    input  logic        apb_request__pwrite,
    input  logic [31:0] apb_request__pwdata,
    output logic [31:0] apb_response__prdata,
    output logic        apb_response__pready,
    output logic        apb_response__perr,
    input  logic        capture_valid,
    input  logic [31:0] capture_data,
    output logic        capture_ready,
    output logic        fifo_irq
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [CW-1:0]              cnt_t;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_THRESH = 2'd2,
        REG_PEEK   = 2'd3
    } reg_addr_t;

    logic [31:0] mem [DEPTH];
    ptr_t        wr_ptr, rd_ptr;
    cnt_t        count, count_next;
    cnt_t        threshold, threshold_next;
    logic        overflow, overflow_next;
    logic        underflow, underflow_next;
    logic        irq_next;

    logic        access, rd_access, wr_access;
    reg_addr_t   addr;
    logic        empty, full;
    logic        push, pop, drop, data_underrun;
    logic [31:0] head;
    logic [31:0] status_word;
    logic        unused_bits;

    assign addr      = reg_addr_t'(apb_request__paddr[3:2]);
    assign access    = apb_request__psel & apb_request__penable;
    assign rd_access = access & ~apb_request__pwrite;
    assign wr_access = access &  apb_request__pwrite;

    assign empty = (count == '0);
    assign full  = (count == cnt_t'(DEPTH));
    assign head  = mem[rd_ptr];

    // Full/empty are judged on the registered count, so a pop never makes room for a same-cycle capture.
    assign push          = capture_valid & ~full;
    assign drop          = capture_valid &  full;
    assign pop           = rd_access & (addr == REG_DATA) & ~empty;
    assign data_underrun = rd_access & (addr == REG_DATA) &  empty;

    assign status_word = {16'h0, 8'(count), 4'h0, underflow, overflow, full, empty};

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + cnt_t'(1);
        end else if (pop && !push) begin
            count_next = count - cnt_t'(1);
        end
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    always_comb begin
        overflow_next  = overflow;
        underflow_next = underflow;
        threshold_next = threshold;
        if (wr_access && addr == REG_STATUS) begin
            if (apb_request__pwdata[2]) overflow_next  = 1'b0;
            if (apb_request__pwdata[3]) underflow_next = 1'b0;
        end
        if (wr_access && addr == REG_THRESH) begin
            threshold_next = apb_request__pwdata[CW-1:0];
        end
        if (drop)          overflow_next  = 1'b1;
        if (data_underrun) underflow_next = 1'b1;
    end

    assign irq_next = ((threshold_next != '0) && (count_next >= threshold_next)) | overflow_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            threshold <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            fifo_irq  <= 1'b0;
        end else if (clk__enable) begin
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            count     <= count_next;
            threshold <= threshold_next;
            overflow  <= overflow_next;
            underflow <= underflow_next;
            fifo_irq  <= irq_next;
        end
    end

    // Storage is deliberately left out of reset; count=0 makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (clk__enable && push) begin
            mem[wr_ptr] <= capture_data;
        end
    end

    always_comb begin
        apb_response__prdata = '0;
        apb_response__perr   = 1'b0;
        if (rd_access) begin
            case (addr)
                REG_DATA: begin
                    if (empty) apb_response__perr   = 1'b1;
                    else       apb_response__prdata = head;
                end
                REG_STATUS: apb_response__prdata = status_word;
                REG_THRESH: apb_response__prdata = 32'(threshold);
                REG_PEEK:   if (!empty) apb_response__prdata = head;
                default:    apb_response__prdata = '0;
            endcase
        end
    end

    assign apb_response__pready = 1'b1;
    assign capture_ready        = ~full;

    assign unused_bits = ^{apb_request__paddr, apb_request__pwdata};

endmodule

// File: tb/tb_apb_target_capture_fifo.sv
// Directed bench for apb_target_capture_fifo: APB register access, capture strobes,
// overflow/underflow races, threshold interrupt, pointer wrap and asynchronous reset.
module tb_apb_target_capture_fifo;

    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_THRESH = 32'h8;
    localparam logic [31:0] A_PEEK   = 32'hC;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        reset_n = 1'b0;
    logic [31:0] paddr = '0;
    logic        penable = 1'b0;
    logic        psel = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        perr;
    logic        capture_valid = 1'b0;
    logic [31:0] capture_data = '0;
    logic        capture_ready;
    logic        fifo_irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    apb_target_capture_fifo #(.FIFO_DEPTH_LOG2(3)) dut (
        .clk                  (clk),
        .clk__enable          (clk_en),
        .reset_n              (reset_n),
        .apb_request__paddr   (paddr),
        .apb_request__penable (penable),
        .apb_request__psel    (psel),
        .apb_request__pwrite  (pwrite),
        .apb_request__pwdata  (pwdata),
        .apb_response__prdata (prdata),
        .apb_response__pready (pready),
        .apb_response__perr   (perr),
        .capture_valid        (capture_valid),
        .capture_data         (capture_data),
        .capture_ready        (capture_ready),
        .fifo_irq             (fifo_irq)
    );

    always #5 clk = ~clk;

    // Drivers: each task starts at a falling edge and ends 1ns after the completing rising edge.
    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1;
        d = prdata; e = perr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] wd, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        #1;
        e = perr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] d);
        @(negedge clk);
        capture_valid = 1'b1; capture_data = d;
        @(posedge clk);
        #1;
        capture_valid = 1'b0;
    endtask

    task automatic push_pop(input logic [31:0] d, output logic [31:0] rd, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_DATA;
        @(negedge clk);
        penable = 1'b1; capture_valid = 1'b1; capture_data = d;
        #1;
        rd = prdata; e = perr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; capture_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL reset_idle_prdata got %h want 00000000", prdata); end
        n_checks++; if (pready !== 1'b1) begin n_fail++; $display("FAIL reset_pready got %b want 1", pready); end
        n_checks++; if (fifo_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", fifo_irq); end
        n_checks++; if (capture_ready !== 1'b1) begin n_fail++; $display("FAIL reset_capture_ready got %b want 1", capture_ready); end
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status got %h want 00000001", d); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL reset_status_err got %b want 0", e); end
        apb_read(A_THRESH, d, e);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_thresh got %h want 00000000", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d; logic e;
        logic [31:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        for (int i = 0; i < 3; i++) strobe(words[i]);
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0300) begin n_fail++; $display("FAIL basic_status_count3 got %h want 00000300", d); end
        apb_read(A_PEEK, d, e);
        n_checks++; if (d !== 32'h11 || e !== 1'b0) begin n_fail++; $display("FAIL basic_peek got %h/%b want 00000011/0", d, e); end
        for (int i = 0; i < 3; i++) begin
            apb_read(A_DATA, d, e);
            n_checks++; if (d !== words[i] || e !== 1'b0) begin n_fail++; $display("FAIL basic_pop%0d got %h/%b want %h/0", i, d, e, words[i]); end
        end
        apb_read(A_DATA, d, e);
        n_checks++; if (d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL basic_underrun got %h/%b want 00000000/1", d, e); end
        apb_read(A_PEEK, d, e);
        n_checks++; if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL basic_peek_empty got %h/%b want 00000000/0", d, e); end
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0009) begin n_fail++; $display("FAIL basic_underflow_flag got %h want 00000009", d); end
        apb_write(A_STATUS, 32'h8, e);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_w1c_err got %b want 0", e); end
        apb_write(A_DATA, 32'hDEAD_BEEF, e);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_data_write_err got %b want 0", e); end
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL basic_status_cleared got %h want 00000001", d); end
    endtask

    task automatic test_empty_race();
        logic [31:0] d; logic e;
        push_pop(32'hE1, d, e);
        n_checks++; if (d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL race_empty_read got %h/%b want 00000000/1", d, e); end
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0108) begin n_fail++; $display("FAIL race_empty_status got %h want 00000108", d); end
        apb_write(A_STATUS, 32'h8, e);
        apb_read(A_DATA, d, e);
        n_checks++; if (d !== 32'hE1 || e !== 1'b0) begin n_fail++; $display("FAIL race_empty_landed got %h/%b want 000000e1/0", d, e); end
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL race_empty_final got %h want 00000001", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic e;
        for (int i = 0; i < 8; i++) strobe(32'hA0 + 32'(i));
        n_checks++; if (capture_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_capture_ready got %b want 0", capture_ready); end
        n_checks++; if (fifo_irq !== 1'b0) begin n_fail++; $display("FAIL ovf_irq_before_drop got %b want 0", fifo_irq); end
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0802) begin n_fail++; $display("FAIL ovf_status_full got %h want 00000802", d); end
        strobe(32'hBAD);
        n_checks++; if (fifo_irq !== 1'b1) begin n_fail++; $display("FAIL ovf_irq_after_drop got %b want 1", fifo_irq); end
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0806) begin n_fail++; $display("FAIL ovf_status_drop got %h want 00000806", d); end
        apb_write(A_STATUS, 32'h4, e);
        n_checks++; if (fifo_irq !== 1'b0) begin n_fail++; $display("FAIL ovf_irq_cleared got %b want 0", fifo_irq); end
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0802) begin n_fail++; $display("FAIL ovf_status_w1c got %h want 00000802", d); end
        // Pop and capture together while full: the capture is still dropped.
        push_pop(32'hEE, d, e);
        n_checks++; if (d !== 32'hA0 || e !== 1'b0) begin n_fail++; $display("FAIL ovf_full_race_pop got %h/%b want 000000a0/0", d, e); end
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0704) begin n_fail++; $display("FAIL ovf_full_race_status got %h want 00000704", d); end
        apb_write(A_STATUS, 32'h4, e);
        for (int i = 1; i < 8; i++) begin
            apb_read(A_DATA, d, e);
            n_checks++; if (d !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL ovf_drain%0d got %h want %h", i, d, 32'hA0 + 32'(i)); end
        end
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL ovf_final_status got %h want 00000001", d); end
    endtask

    task automatic test_threshold();
        logic [31:0] d; logic e;
        apb_write(A_THRESH, 32'hFFFF_FFF4, e);
        apb_read(A_THRESH, d, e);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL thr_readback got %h want 00000004", d); end
        for (int i = 0; i < 3; i++) strobe(32'h40 + 32'(i));
        n_checks++; if (fifo_irq !== 1'b0) begin n_fail++; $display("FAIL thr_irq_at3 got %b want 0", fifo_irq); end
        strobe(32'h43);
        n_checks++; if (fifo_irq !== 1'b1) begin n_fail++; $display("FAIL thr_irq_at4 got %b want 1", fifo_irq); end
        apb_read(A_DATA, d, e);
        n_checks++; if (d !== 32'h40) begin n_fail++; $display("FAIL thr_pop got %h want 00000040", d); end
        n_checks++; if (fifo_irq !== 1'b0) begin n_fail++; $display("FAIL thr_irq_after_pop got %b want 0", fifo_irq); end
        for (int i = 1; i < 4; i++) apb_read(A_DATA, d, e);
        // Threshold beyond depth: the level term can never fire.
        apb_write(A_THRESH, 32'h9, e);
        for (int i = 0; i < 8; i++) strobe(32'h70 + 32'(i));
        n_checks++; if (fifo_irq !== 1'b0) begin n_fail++; $display("FAIL thr_over_depth_irq got %b want 0", fifo_irq); end
        for (int i = 0; i < 8; i++) begin
            apb_read(A_DATA, d, e);
            n_checks++; if (d !== 32'h70 + 32'(i)) begin n_fail++; $display("FAIL thr_drain%0d got %h want %h", i, d, 32'h70 + 32'(i)); end
        end
        apb_write(A_THRESH, 32'h0, e);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, exp_d, nd; logic e;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            strobe(32'h50 + 32'(i));
            exp_q.push_back(32'h50 + 32'(i));
        end
        for (int i = 0; i < 21; i++) begin
            nd = 32'h60 + 32'(i);
            exp_d = exp_q.pop_front();
            exp_q.push_back(nd);
            push_pop(nd, d, e);
            n_checks++; if (d !== exp_d || e !== 1'b0) begin n_fail++; $display("FAIL b2b_pop%0d got %h/%b want %h/0", i, d, e, exp_d); end
            if (i == 0) begin
                apb_read(A_STATUS, d, e);
                n_checks++; if (d !== 32'h0000_0500) begin n_fail++; $display("FAIL b2b_count_kept got %h want 00000500", d); end
            end
        end
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0500) begin n_fail++; $display("FAIL b2b_count_end got %h want 00000500", d); end
        while (exp_q.size() > 0) begin
            exp_d = exp_q.pop_front();
            apb_read(A_DATA, d, e);
            n_checks++; if (d !== exp_d) begin n_fail++; $display("FAIL b2b_drain got %h want %h", d, exp_d); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic e;
        for (int i = 0; i < 9; i++) strobe(32'hC0 + 32'(i));
        apb_read(A_DATA, d, e);
        apb_read(A_DATA, d, e);
        apb_read(A_STATUS, d, e);
        n_checks++; if (d !== 32'h0000_0604) begin n_fail++; $display("FAIL ares_pre_status got %h want 00000604", d); end
        n_checks++; if (fifo_irq !== 1'b1) begin n_fail++; $display("FAIL ares_pre_irq got %b want 1", fifo_irq); end
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = A_STATUS;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (prdata !== 32'h0000_0001) begin n_fail++; $display("FAIL ares_status got %h want 00000001", prdata); end
        n_checks++; if (fifo_irq !== 1'b0) begin n_fail++; $display("FAIL ares_irq got %b want 0", fifo_irq); end
        n_checks++; if (capture_ready !== 1'b1) begin n_fail++; $display("FAIL ares_capture_ready got %b want 1", capture_ready); end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        strobe(32'hD0);
        apb_read(A_PEEK, d, e);
        n_checks++; if (d !== 32'hD0) begin n_fail++; $display("FAIL ares_resume_peek got %h want 000000d0", d); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_empty_race();
        test_overflow();
        test_threshold();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
